// File: rtl/poly1305_pkg.sv
// Shared Poly1305 datapath constants and types for the multiplier and reducer.
// The field modulus is p = 2^130 - 5.
package poly1305_pkg;

    localparam int unsigned W_PROD = 258;
    localparam int unsigned W_RES  = 130;

    localparam logic [W_RES-1:0] P130 = {2'b11, {124{1'b1}}, 4'hB};

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        SUB
    } state_t;

endpackage

// File: rtl/poly1305_fold.sv
// One combinational fold step: lo + 5*hi, where 2^130 is congruent to 5 mod p.
// The fold of any 258-bit value fits in 132 bits, so the upper bits are zero.
module poly1305_fold
    import poly1305_pkg::*;
(
    input  logic [W_PROD-1:0] acc_in,
    output logic [W_PROD-1:0] acc_out
);

    localparam int unsigned W_HI  = W_PROD - W_RES;
    localparam int unsigned W_SUM = W_RES + 2;

    logic [W_HI-1:0]  hi;
    logic [W_RES-1:0] lo;
    logic [W_SUM-1:0] sum;

    always_comb begin
        hi      = acc_in[W_PROD-1:W_RES];
        lo      = acc_in[W_RES-1:0];
        sum     = {2'b00, lo} + {2'b00, hi, 2'b00} + {4'b0000, hi};
        acc_out = {{(W_PROD - W_SUM){1'b0}}, sum};
    end

endmodule

// File: rtl/poly1305_reduce_258.sv
// Sequential reducer: a 258-bit product goes through FOLDS fold cycles and one
// conditional subtract of p, giving the canonical residue. Fixed latency FOLDS+1.
module poly1305_reduce_258
    import poly1305_pkg::*;
#(
    parameter int unsigned FOLDS = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [W_PROD-1:0] prod_in,
    output logic [W_RES-1:0]  r_out,
    output logic              busy,
    output logic              done,
    output logic              err_overrun
);

    localparam int unsigned      CNT_W = $clog2(FOLDS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FOLDS - 1);

    state_t            state_q, state_d;
    logic [W_PROD-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W_RES-1:0]  r_q, r_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [W_PROD-1:0] fold_out;
    logic [W_RES-1:0]  acc_lo;

    poly1305_fold u_fold (
        .acc_in  (acc_q),
        .acc_out (fold_out)
    );

    assign acc_lo = acc_q[W_RES-1:0];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        done_d  = 1'b0;
        // Any start outside IDLE (SUB included) is dropped and flagged.
        err_d   = start && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = prod_in;
                    cnt_d   = '0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                acc_d = fold_out;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                // After the folds acc < 2^130 < 2p, so one subtract is enough.
                r_d     = (acc_lo >= P130) ? (acc_lo - P130) : acc_lo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign r_out       = r_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_poly1305_reduce_258.sv
// Directed and random checks of the Poly1305 reducer against a modulus model.
module tb_poly1305_reduce_258;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [257:0] prod_in;
    logic [129:0] r_out;
    logic         busy;
    logic         done;
    logic         err_overrun;

    int checks   = 0;
    int failures = 0;

    logic [257:0] p_mod;
    logic [257:0] two130;
    logic [257:0] all_ones;
    logic [129:0] res;
    int           lat;
    int           bcnt;
    int           errs;
    int           dones;

    poly1305_reduce_258 #(.FOLDS(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .prod_in     (prod_in),
        .r_out       (r_out),
        .busy        (busy),
        .done        (done),
        .err_overrun (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [257:0] obs, input logic [257:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its done pulse.
    task automatic do_op(input logic [257:0] v, output logic [129:0] r, output int l,
                         output int bc);
        @(negedge clk);
        start   = 1'b1;
        prod_in = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        l  = 0;
        bc = busy ? 1 : 0;
        while (!done && l < 20) begin
            @(posedge clk);
            #1;
            l++;
            if (busy) bc++;
        end
        r = r_out;
    endtask

    initial begin
        p_mod    = (258'(1) << 130) - 258'd5;
        two130   = 258'(1) << 130;
        all_ones = '1;
        start    = 1'b0;
        prod_in  = '0;
        reset_n  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_r_out", 258'(r_out), 258'd0);
        chk("reset_busy", 258'(busy), 258'd0);
        chk("reset_done", 258'(done), 258'd0);
        chk("reset_err", 258'(err_overrun), 258'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Zero input: latency and busy duration.
        do_op(258'd0, res, lat, bcnt);
        chk("zero_r", 258'(res), 258'd0);
        chk("zero_latency", 258'(lat), 258'd4);
        chk("zero_busy_cycles", 258'(bcnt), 258'd4);
        chk("zero_busy_low_at_done", 258'(busy), 258'd0);
        @(posedge clk);
        #1;
        chk("zero_done_single", 258'(done), 258'd0);
        chk("zero_r_held", 258'(r_out), 258'd0);

        // Subtract-path boundaries.
        do_op(p_mod, res, lat, bcnt);
        chk("p_r", 258'(res), 258'd0);
        do_op(p_mod + 258'd1, res, lat, bcnt);
        chk("p_plus1_r", 258'(res), 258'd1);
        do_op(two130 - 258'd1, res, lat, bcnt);
        chk("two130_m1_r", 258'(res), 258'd4);
        do_op(two130, res, lat, bcnt);
        chk("two130_r", 258'(res), 258'd5);
        do_op(all_ones, res, lat, bcnt);
        chk("all_ones_r", 258'(res), (258'(1) << 128) + 258'd4);
        chk("all_ones_latency", 258'(lat), 258'd4);

        // Overrun: extra starts at edges 2 and 4 are dropped.
        errs = 0;
        @(negedge clk);
        start   = 1'b1;
        prod_in = two130;
        @(posedge clk);                 // edge 0
        #1;
        start   = 1'b0;
        prod_in = 258'd99;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);                 // edge 2
        #1;
        start = 1'b0;
        chk("ovr_err_edge2", 258'(err_overrun), 258'd1);
        if (err_overrun) errs++;
        @(posedge clk);                 // edge 3
        #1;
        chk("ovr_err_edge3_low", 258'(err_overrun), 258'd0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);                 // edge 4
        #1;
        start = 1'b0;
        chk("ovr_err_edge4", 258'(err_overrun), 258'd1);
        if (err_overrun) errs++;
        chk("ovr_done_edge4", 258'(done), 258'd1);
        chk("ovr_r", 258'(r_out), 258'd5);
        chk("ovr_err_count", 258'(errs), 258'd2);

        // Back-to-back: start during the done cycle is accepted.
        do_op(258'd7, res, lat, bcnt);
        chk("b2b_r", 258'(res), 258'd7);
        chk("b2b_latency", 258'(lat), 258'd4);
        chk("b2b_err_low", 258'(err_overrun), 258'd0);

        // Reset mid-operation at edge 2.
        @(negedge clk);
        start   = 1'b1;
        prod_in = all_ones;
        @(posedge clk);                 // edge 0
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);                 // edge 2
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", 258'(busy), 258'd0);
        chk("rst_mid_r", 258'(r_out), 258'd0);
        chk("rst_mid_done", 258'(done), 258'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("rst_mid_no_done", 258'(dones), 258'd0);
        do_op(two130 + 258'd3, res, lat, bcnt);
        chk("rst_after_r", 258'(res), 258'd8);
        chk("rst_after_latency", 258'(lat), 258'd4);

        // Random vectors against a plain modulus model.
        for (int i = 0; i < 10000; i++) begin
            logic [257:0] v;
            logic [257:0] expv;
            v = '0;
            for (int w = 0; w < 9; w++) begin
                v = (v << 32) | 258'($urandom);
            end
            expv = v % p_mod;
            do_op(v, res, lat, bcnt);
            chk("rand_r", 258'(res), expv);
            chk("rand_lt_p", 258'(258'(res) < p_mod), 258'd1);
            chk("rand_latency", 258'(lat), 258'd4);
        end
        @(posedge clk);
        #1;
        chk("rand_done_single", 258'(done), 258'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
